// File: rtl/spi_burst_master.sv
// ---------------------------------------------------------------------------
// spi_burst_master
//
// SPI master (mode 3: SPC idles high, SDI launched on the falling edge, SDO
// sampled on the rising edge) for the inertial sensor path. One transaction
// sends a header (R/W + address) and then a burst of 1..MAX_BYTES data bytes
// under a single CS assertion.
//
// Optional build macro:
//   SPI_MS_BIT_EN - header becomes R/W, MS, addr[ADDR_W-2:0]; MS=1 when the
//                   clamped burst length is greater than one (auto-increment).
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   start       transaction request, only looked at while idle
//   read        1 = read transaction, 0 = write
//   addr        register address placed in the header
//   nbytes      burst length; 0 runs as 1, values above MAX_BYTES clamp
//   wdata       write bytes, byte k = wdata[8k+7:8k], byte 0 sent first
//   SDO         serial data from the slave
//   SPC, CS     serial clock and active-low chip select
//   SDI         serial data to the slave
//   rdata       read bytes, same packing as wdata
//   busy        high from the cycle after start is accepted through DONE
//   done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module spi_burst_master #(
    parameter int CLK_DIV   = 1,
    parameter int MAX_BYTES = 6,
    parameter int ADDR_W    = 7,
    parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   read,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [NB_W-1:0]        nbytes,
    input  logic [8*MAX_BYTES-1:0] wdata,
    input  logic                   SDO,
    output logic                   SPC,
    output logic                   CS,
    output logic                   SDI,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   busy,
    output logic                   done
);

    // state  | meaning
    // -------+--------------------------------------------------------------
    // IDLE   | CS high, waiting for start
    // SETUP  | CS low, SPC high, first bit already on SDI
    // LOW    | SPC low half-period, SDI launched on entry
    // HIGH   | SPC high half-period, SDO captured on entry
    // DONE   | one cycle: CS high, done pulse, busy still high

    localparam int HDR_BITS = 1 + ADDR_W;
    localparam int DATA_W   = 8 * MAX_BYTES;
    localparam int TX_W     = HDR_BITS + DATA_W;
    localparam int BIT_W    = $clog2(TX_W + 1);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RX_IW    = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
    logic [BIT_W-1:0]    last_idx_q, last_idx_d;
    logic                rd_q, rd_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                spc_q, spc_d;
    logic                cs_q, cs_d;
    logic                sdi_q, sdi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                div_tc;
    logic                last_bit;
    logic                accept;
    logic                advance;
    logic                capture;
    logic [NB_W-1:0]     nb_eff;
    logic [BIT_W-1:0]    n_last;
    logic [ADDR_W-1:0]   hdr_addr;
    logic [DATA_W-1:0]   tx_payload;
    logic [RX_IW-1:0]    data_pos;

    assign div_tc   = (div_cnt_q == '0);
    assign last_bit = (bit_idx_q == last_idx_q);
    assign accept   = (state_q == S_IDLE) && start;
    assign advance  = (state_q == S_HIGH) && div_tc && !last_bit;
    // SPC rises on the edge that leaves the last LOW cycle.
    assign capture  = (state_q == S_LOW) && div_tc;

    always_comb begin
        nb_eff = nbytes;
        if (nbytes == '0) begin
            nb_eff = NB_W'(1);
        end else if (nbytes > NB_W'(MAX_BYTES)) begin
            nb_eff = NB_W'(MAX_BYTES);
        end
    end

    // Index of the final bit: header bits plus eight per byte, minus one.
    assign n_last = BIT_W'(HDR_BITS - 1) + BIT_W'({nb_eff, 3'b000});

`ifdef SPI_MS_BIT_EN
    logic ms_bit;
    assign ms_bit   = (nb_eff > NB_W'(1));
    assign hdr_addr = {ms_bit, addr[ADDR_W-2:0]};
`else
    assign hdr_addr = addr;
`endif

    // Byte 0 goes to the top of the shift register so it leaves first.
    // Reads shift out zeros during the data phase.
    always_comb begin
        tx_payload = '0;
        if (!read) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
                tx_payload[8*(MAX_BYTES-1-k) +: 8] = wdata[8*k +: 8];
            end
        end
    end

    // Data bit d lands at byte d/8, bit 7-(d%8); flipping the low three bits
    // of d gives exactly that flat rdata position.
    assign data_pos = RX_IW'(bit_idx_q - BIT_W'(HDR_BITS)) ^ RX_IW'(7);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_SETUP;
            S_SETUP: if (div_tc) state_d = S_LOW;
            S_LOW:   if (div_tc) state_d = S_HIGH;
            S_HIGH:  if (div_tc) state_d = last_bit ? S_DONE : S_LOW;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the registered pin outputs, derived from the state
    // being entered so the pins line up with the state register.
    always_comb begin
        cs_d   = !(state_d inside {S_SETUP, S_LOW, S_HIGH});
        spc_d  = (state_d != S_LOW);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        sdi_d  = sdi_q;
        if (accept) begin
            sdi_d = read;
        end else if (advance) begin
            sdi_d = tx_q[TX_W-2];
        end else if (state_d == S_IDLE || state_d == S_DONE) begin
            sdi_d = 1'b0;
        end
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        div_cnt_d  = div_cnt_q;
        bit_idx_d  = bit_idx_q;
        last_idx_d = last_idx_q;
        rd_d       = rd_q;
        tx_d       = tx_q;
        rdata_d    = rdata_q;

        // Half-period timer: reload on entry to any timed state, count down
        // to zero and park there.
        if ((state_d != state_q) && (state_d inside {S_SETUP, S_LOW, S_HIGH})) begin
            div_cnt_d = DIV_W'(CLK_DIV - 1);
        end else if (!div_tc) begin
            div_cnt_d = div_cnt_q - DIV_W'(1);
        end

        if (accept) begin
            rd_d       = read;
            last_idx_d = n_last;
            bit_idx_d  = '0;
            tx_d       = {read, hdr_addr, tx_payload};
            rdata_d    = '0;
        end

        if (capture && rd_q && (bit_idx_q >= BIT_W'(HDR_BITS))) begin
            rdata_d[data_pos] = SDO;
        end

        if (advance) begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            tx_d      = tx_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            bit_idx_q  <= '0;
            last_idx_q <= '0;
            rd_q       <= 1'b0;
            tx_q       <= '0;
            rdata_q    <= '0;
            spc_q      <= 1'b1;
            cs_q       <= 1'b1;
            sdi_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_idx_q  <= bit_idx_d;
            last_idx_q <= last_idx_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            rdata_q    <= rdata_d;
            spc_q      <= spc_d;
            cs_q       <= cs_d;
            sdi_q      <= sdi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SPC   = spc_q;
    assign CS    = cs_q;
    assign SDI   = sdi_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// ---------------------------------------------------------------------------
// tb_spi_burst_master
//
// Directed bench for spi_burst_master. Instance A uses the default
// parameters, instance B uses CLK_DIV=4. A small slave model per instance
// shifts a preset stream onto SDO on every SPC falling edge, and a monitor
// records SDI on every SPC rising edge.
// ---------------------------------------------------------------------------
module tb_spi_burst_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        read;
    logic [6:0]  addr;
    logic [2:0]  nbytes;
    logic [47:0] wdata;

    logic        start_a, spc_a, cs_a, sdi_a, busy_a, done_a;
    logic        sdo_a = 1'b0;
    logic [47:0] rdata_a;
    logic        start_b, spc_b, cs_b, sdi_b, busy_b, done_b;
    logic        sdo_b = 1'b0;
    logic [47:0] rdata_b;

    int checks = 0;
    int errors = 0;

    spi_burst_master u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .read(read), .addr(addr),
        .nbytes(nbytes), .wdata(wdata), .SDO(sdo_a), .SPC(spc_a), .CS(cs_a),
        .SDI(sdi_a), .rdata(rdata_a), .busy(busy_a), .done(done_a)
    );

    spi_burst_master #(.CLK_DIV(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .read(read), .addr(addr),
        .nbytes(nbytes), .wdata(wdata), .SDO(sdo_b), .SPC(spc_b), .CS(cs_b),
        .SDI(sdi_b), .rdata(rdata_b), .busy(busy_b), .done(done_b)
    );

    // SDI history at SPC rising edges, newest bit in bit 0.
    logic [63:0] sdi_cap_a = '0;
    logic [63:0] sdi_cap_b = '0;
    int          rise_a = 0;
    int          rise_b = 0;
    always @(posedge spc_a) begin sdi_cap_a = {sdi_cap_a[62:0], sdi_a}; rise_a++; end
    always @(posedge spc_b) begin sdi_cap_b = {sdi_cap_b[62:0], sdi_b}; rise_b++; end

    // Slave: stream bit k (pat MSB first) goes out on the k-th SPC fall.
    logic [63:0] pat_a = '0;
    logic [63:0] pat_b = '0;
    int          fall_a = 0;
    int          fall_b = 0;
    always @(negedge spc_a or posedge cs_a) begin
        if (cs_a) fall_a = 0;
        else begin
            sdo_a = (fall_a < 64) ? pat_a[63-fall_a] : 1'b0;
            fall_a++;
        end
    end
    always @(negedge spc_b or posedge cs_b) begin
        if (cs_b) fall_b = 0;
        else begin
            sdo_b = (fall_b < 64) ? pat_b[63-fall_b] : 1'b0;
            fall_b++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the shared inputs already set. Cycle 1 is the
    // first negedge after the start-accept edge.
    task automatic run_xfer(input bit sel, input int mid_start, input int budget,
                            output int cs_low, output int done_cyc, output int done_cnt,
                            output int spc_low, output logic [3:0] first);
        cs_low = 0; done_cyc = -1; done_cnt = 0; spc_low = 0; first = 'x;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_a = 1'b0; start_b = 1'b0;
                first = sel ? {cs_b, busy_b, spc_b, sdi_b} : {cs_a, busy_a, spc_a, sdi_a};
            end
            if (c == mid_start) begin if (sel) start_b = 1'b1; else start_a = 1'b1; end
            if (c == mid_start + 1) begin start_a = 1'b0; start_b = 1'b0; end
            if (!(sel ? cs_b : cs_a)) cs_low++;
            if (!(sel ? spc_b : spc_a)) spc_low++;
            if (sel ? done_b : done_a) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc > 0 && c >= done_cyc + 3) break;
        end
    endtask

    int          cs_low, done_cyc, done_cnt, spc_low, r0;
    logic [3:0]  first;

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        read = 1'b0; addr = '0; nbytes = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {cs_a, spc_a, sdi_a, busy_a, done_a}, 5'b11000);
        chk("rst_rdata_a", rdata_a, 48'h0);
        chk("rst_outs_b", {cs_b, spc_b, sdi_b, busy_b, done_b}, 5'b11000);
        reset = 1'b0;
        @(negedge clk);

        // T1: write 0x57 to 0x20, one byte
        read = 1'b0; addr = 7'h20; nbytes = 3'd1; wdata = 48'h57; pat_a = '1;
        r0 = rise_a;
        run_xfer(1'b0, 0, 80, cs_low, done_cyc, done_cnt, spc_low, first);
        chk("t1_first_cycle", first, 4'b0110);
        chk("t1_sdi", sdi_cap_a[15:0], 16'h2057);
        chk("t1_rises", rise_a - r0, 16);
        chk("t1_cs_low", cs_low, 33);
        chk("t1_done_cyc", done_cyc, 34);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_spc_low", spc_low, 16);
        chk("t1_rdata", rdata_a, 48'h0);

        // T2: read 0x0F, slave returns 0x33, stray start mid-transfer
        read = 1'b1; addr = 7'h0F; nbytes = 3'd1; wdata = '0;
        pat_a = 64'hFF33_FFFF_FFFF_FFFF;
        r0 = rise_a;
        run_xfer(1'b0, 10, 80, cs_low, done_cyc, done_cnt, spc_low, first);
        chk("t2_first_cycle", first, 4'b0111);
        chk("t2_sdi", sdi_cap_a[15:0], 16'h8F00);
        chk("t2_rdata", rdata_a, 48'h33);
        chk("t2_done_cyc", done_cyc, 34);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_cs_low", cs_low, 33);

        // T3: three-byte write, rdata cleared and SDO ignored
        read = 1'b0; addr = 7'h55; nbytes = 3'd3; wdata = 48'h0000_00C3_B2A1;
        pat_a = '1;
        r0 = rise_a;
        run_xfer(1'b0, 0, 120, cs_low, done_cyc, done_cnt, spc_low, first);
        chk("t3_sdi", sdi_cap_a[31:0], 32'h55A1_B2C3);
        chk("t3_rises", rise_a - r0, 32);
        chk("t3_cs_low", cs_low, 65);
        chk("t3_done_cyc", done_cyc, 66);
        chk("t3_rdata", rdata_a, 48'h0);

        // T4: nbytes=0 runs as one byte
        read = 1'b1; addr = 7'h01; nbytes = 3'd0;
        pat_a = 64'h009C_FFFF_FFFF_FFFF;
        r0 = rise_a;
        run_xfer(1'b0, 0, 80, cs_low, done_cyc, done_cnt, spc_low, first);
        chk("t4_rises", rise_a - r0, 16);
        chk("t4_cs_low", cs_low, 33);
        chk("t4_rdata", rdata_a, 48'h9C);

        // T5: nbytes=7 clamps to six bytes
        read = 1'b1; addr = 7'h7F; nbytes = 3'd7;
        pat_a = 64'h0011_2233_4455_66FF;
        r0 = rise_a;
        run_xfer(1'b0, 0, 200, cs_low, done_cyc, done_cnt, spc_low, first);
        chk("t5_rises", rise_a - r0, 56);
        chk("t5_cs_low", cs_low, 113);
        chk("t5_done_cyc", done_cyc, 114);
        chk("t5_sdi", sdi_cap_a[55:0], 56'hFF_0000_0000_0000);
        chk("t5_rdata", rdata_a, 48'h6655_4433_2211);

        // T6: CLK_DIV=4 instance, six-byte read of 0x01..0x06 from 0x28
        read = 1'b1; addr = 7'h28; nbytes = 3'd6;
        pat_b = 64'hA501_0203_0405_0600;
        r0 = rise_b;
        run_xfer(1'b1, 0, 600, cs_low, done_cyc, done_cnt, spc_low, first);
        chk("t6_rises", rise_b - r0, 56);
        chk("t6_cs_low", cs_low, 452);
        chk("t6_done_cyc", done_cyc, 453);
        chk("t6_spc_low", spc_low, 224);
        chk("t6_rdata", rdata_b, 48'h0605_0403_0201);
`ifdef SPI_MS_BIT_EN
        chk("t6_sdi", sdi_cap_b[55:0], 56'hE8_0000_0000_0000);
`else
        chk("t6_sdi", sdi_cap_b[55:0], 56'hA8_0000_0000_0000);
`endif

        // T7: reset once the tenth bit has been sampled
        begin
            bit found;
            read = 1'b1; addr = 7'h12; nbytes = 3'd2; pat_a = '1;
            found = 1'b0;
            r0 = rise_a;
            start_a = 1'b1;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                start_a = 1'b0;
                if (rise_a - r0 == 10) begin found = 1'b1; break; end
            end
            chk("t7_bit10_reached", found, 1'b1);
            chk("t7_partial_rdata", rdata_a, 48'hC0);
            reset = 1'b1;
            @(negedge clk);
            chk("t7_outs_after_reset", {cs_a, spc_a, sdi_a, busy_a, done_a}, 5'b11000);
            chk("t7_rdata_after_reset", rdata_a, 48'h0);
            reset = 1'b0;
            cs_low = 0; done_cnt = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (!cs_a) cs_low++;
                if (done_a) done_cnt++;
            end
            chk("t7_no_done", done_cnt, 0);
            chk("t7_cs_stays_high", cs_low, 0);
        end

        // T8: start held high gives back-to-back transfers
        begin
            int  gap, cur_gap, low_run, last_low_run;
            bit  prev_cs;
            read = 1'b0; addr = 7'h33; nbytes = 3'd1; wdata = 48'h0F;
            gap = -1; cur_gap = 0; low_run = 0; last_low_run = 0; done_cnt = 0;
            prev_cs = 1'b1;
            start_a = 1'b1;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (!cs_a) begin
                    if (prev_cs && done_cnt == 1 && gap < 0) gap = cur_gap;
                    low_run++;
                end else begin
                    if (!prev_cs) begin last_low_run = low_run; low_run = 0; cur_gap = 0; end
                    cur_gap++;
                end
                prev_cs = cs_a;
                if (done_a) done_cnt++;
                if (done_cnt == 2) begin start_a = 1'b0; break; end
            end
            repeat (3) @(negedge clk);
            chk("t8_done_cnt", done_cnt, 2);
            chk("t8_cs_high_gap", gap, 2);
            chk("t8_second_cs_low", last_low_run, 33);
            chk("t8_idle_after", {cs_a, busy_a}, 2'b10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_burst_master.md
# spi_burst_master

Parametrised SPI master for the on-board inertial sensor path and the next generation of the single-byte register SPI engine. It runs mode 3 (SPC idles high, SDI changes on the falling edge, SDO is sampled on the rising edge) at a programmable clock divide. Each transaction sends a header (R/W plus address) followed by a burst of 1..MAX_BYTES data bytes under one CS assertion. It sits between the sensor-polling controller and the chip pins.

## Interface
- CLK_DIV, default 1: clk cycles per SPC half-period, at least 1.
- MAX_BYTES, default 6: largest burst length in bytes.
- ADDR_W, default 7: address bits in the header after R/W.
- NB_W, default $clog2(MAX_BYTES+1): width of `nbytes`.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- read  in  1  1 = read transaction, 0 = write.
- addr  in  ADDR_W  register address.
- nbytes  in  NB_W  burst length. 0 is treated as 1; values above MAX_BYTES are clamped to MAX_BYTES.
- wdata  in  8*MAX_BYTES  write bytes; byte k = wdata[8k+7:8k]; byte 0 is sent first.
- SDO  in  1  serial data from the slave.
- SPC  out  1  serial clock.
- CS  out  1  chip select, active low.
- SDI  out  1  serial data to the slave.
- rdata  out  8*MAX_BYTES  read bytes, same packing as wdata.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SETUP, LOW, HIGH, DONE. All outputs are registered.
- Reset values: CS=1, SPC=1, SDI=0, rdata=0, busy=0, done=0. State goes to IDLE.
- IDLE, start=1 sampled:
  - Latch read, addr, wdata and the clamped nbytes.
  - Clear rdata to 0.
  - Bit count N = 1 + ADDR_W + 8·nbytes.
  - Next cycle: CS=0, busy=1, SDI = R/W bit. Go to SETUP.
- SETUP: CLK_DIV cycles with SPC=1, then go to LOW.
- LOW: CLK_DIV cycles with SPC=0. SDI takes the current bit in the first LOW cycle; the first bit is already on SDI from SETUP. Then go to HIGH.
- HIGH: CLK_DIV cycles with SPC=1.
  - SDO is captured on the clk edge where SPC goes 0→1.
  - After the last HIGH cycle: if bits remain, go to LOW and advance the bit; otherwise go to DONE.
- Bit order:
  - Header first: R/W, then addr MSB first.
  - Then data bytes 0..nbytes-1, each MSB first.
- Read transactions:
  - SDI=0 during the data phase.
  - Data-phase SDO bits fill rdata byte k, MSB first.
  - rdata bytes ≥ nbytes stay 0.
- Write transactions: SDO is ignored and rdata stays 0.
- DONE: one cycle with CS=1, SPC=1, SDI=0, done=1, busy=1. Next state is IDLE.
- start is ignored in every state except IDLE. A start held high across DONE begins a new transaction from IDLE.
- reset mid-transfer aborts the transfer on the next edge. CS rises immediately with no done pulse, and all outputs return to their reset values.

## Timing
- CS-low duration = CLK_DIV + 2·CLK_DIV·N cycles.
- done is asserted at cycle CLK_DIV·(1+2N)+1 after the start-accept edge. CS returns high in the same cycle.
- Defaults, nbytes=1: N=16, CS low for 33 cycles, done at cycle 34.
- SDI is stable for at least CLK_DIV cycles before each SPC rising edge.
- rdata is final and valid in the done cycle and holds until the next accepted start or reset.
- Back-to-back transactions: minimum CS-high time between them is 2 cycles (DONE plus IDLE).

## Configuration
- SPI_MS_BIT_EN defined:
  - The header becomes R/W, MS, addr[ADDR_W-2:0].
  - MS = 1 when the clamped nbytes > 1 (sensor address auto-increment), else 0.
  - N is unchanged.
- SPI_MS_BIT_EN undefined: the header is R/W, addr[ADDR_W-1:0] and there is no MS bit.

## Test plan
- Defaults, write, addr=0x20, nbytes=1, wdata byte0=0x57:
  - SDI at SPC rising edges = 0,0100000,01010111.
  - 16 SPC pulses, CS low 33 cycles, done at cycle 34, rdata=0.
- Defaults, read, addr=0x0F, nbytes=1, slave returns 0x33:
  - SDI header = 1,0001111, then 0s.
  - rdata byte0=0x33, other bytes 0.
- CLK_DIV=4, read, nbytes=6, slave returns 0x01..0x06:
  - Each SPC half-period is 4 cycles; 56 bits.
  - rdata = 0x060504030201.
  - With SPI_MS_BIT_EN, addr=0x28: header = 1,1,101000.
- nbytes=0 runs as 1 byte; nbytes=7 with MAX_BYTES=6 runs 6 bytes.
- start pulsed mid-transfer is ignored. reset asserted at bit 10 gives CS=1, SPC=1, rdata=0 next cycle, and no done pulse.
- start held high continuously gives back-to-back transactions with CS high for exactly 2 cycles between them.
